// File: rtl/regfile_pkg.sv
// Shared constants and the byte-lane merge used by the register file storage and bypass path.
package regfile_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int LANE_W    = 8;

  // One lane of a masked write: take the new byte when enabled, keep the old one otherwise.
  function automatic logic [LANE_W-1:0] lane_merge(
    input logic [LANE_W-1:0] old_b,
    input logic [LANE_W-1:0] new_b,
    input logic              en
  );
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_entry.sv
// One register-file word with per-byte write enables and synchronous clear.
module regfile_entry
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH/LANE_W-1:0]   be,
  input  logic [WIDTH-1:0]          d,
  output logic [WIDTH-1:0]          q
);

  localparam int NB = WIDTH / LANE_W;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      for (int l = 0; l < NB; l++) begin
        q[l*LANE_W +: LANE_W] <= lane_merge(q[l*LANE_W +: LANE_W], d[l*LANE_W +: LANE_W], be[l]);
      end
    end
  end

endmodule

// File: rtl/regfile.sv
// Multi-entry register file: one byte-masked synchronous write port, two combinational read
// ports, optional hardwired-zero entry 0 and optional same-cycle write forwarding.
module regfile
  import regfile_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  DEPTH    = DEF_DEPTH,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 0,
  localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NB       = WIDTH / LANE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_enable,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NB-1:0]    wr_byte_en,
  input  logic [AW-1:0]    rs_addr,
  output logic [WIDTH-1:0] rs_data,
  input  logic [AW-1:0]    rt_addr,
  output logic [WIDTH-1:0] rt_data
);

  // Every encodable address gets a slot so the read mux never indexes past the array;
  // slots at or above DEPTH are constant zero.
  localparam int          NSLOT   = 1 << AW;
  localparam logic [AW:0] DEPTH_V = DEPTH[AW:0];

  if (WIDTH % LANE_W != 0) begin : g_chk_width
    $fatal(1, "regfile: WIDTH must be a multiple of 8");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "regfile: DEPTH must be at least 2");
  end

  logic             wr_legal;
  logic [WIDTH-1:0] q [NSLOT];
  logic [WIDTH-1:0] rs_store, rt_store;
  logic [WIDTH-1:0] rs_merge, rt_merge;
  logic             rs_fwd, rt_fwd;

  // Reset dominates; out-of-range and hardwired-zero targets are dropped silently.
  assign wr_legal = wr_enable && !reset
                 && ({1'b0, wr_addr} < DEPTH_V)
                 && !((ZERO_REG != 0) && (wr_addr == '0));

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if ((i >= DEPTH) || ((ZERO_REG != 0) && (i == 0))) begin : g_const
      assign q[i] = '0;
    end else begin : g_reg
      logic [NB-1:0] be;
      assign be = (wr_legal && (wr_addr == AW'(i))) ? wr_byte_en : '0;
      regfile_entry #(
        .WIDTH (WIDTH)
      ) u_entry (
        .clk   (clk),
        .reset (reset),
        .be    (be),
        .d     (wr_data),
        .q     (q[i])
      );
    end
  end

  assign rs_store = q[rs_addr];
  assign rt_store = q[rt_addr];

  // Forwarded value is what the entry will hold after this edge.
  for (genvar l = 0; l < NB; l++) begin : g_lane
    assign rs_merge[l*LANE_W +: LANE_W] =
      lane_merge(rs_store[l*LANE_W +: LANE_W], wr_data[l*LANE_W +: LANE_W], wr_byte_en[l]);
    assign rt_merge[l*LANE_W +: LANE_W] =
      lane_merge(rt_store[l*LANE_W +: LANE_W], wr_data[l*LANE_W +: LANE_W], wr_byte_en[l]);
  end

  assign rs_fwd  = (BYPASS != 0) && wr_legal && (rs_addr == wr_addr);
  assign rt_fwd  = (BYPASS != 0) && wr_legal && (rt_addr == wr_addr);
  assign rs_data = rs_fwd ? rs_merge : rs_store;
  assign rt_data = rt_fwd ? rt_merge : rt_store;

endmodule

// File: tb/tb_regfile.sv
// Directed table-driven bench for regfile: default config, a ZERO_REG=0/BYPASS=1 config and a DEPTH=20 config share stimulus.
module tb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs0, rt0, rs1, rt1, rs2, rt2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile u0 (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rs_addr(rs_addr), .rs_data(rs0), .rt_addr(rt_addr), .rt_data(rt0)
  );

  regfile #(.ZERO_REG(0), .BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rs_addr(rs_addr), .rs_data(rs1), .rt_addr(rt_addr), .rt_data(rt1)
  );

  regfile #(.DEPTH(20)) u2 (
    .clk(clk), .reset(reset), .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rs_addr(rs_addr), .rs_data(rs2), .rt_addr(rt_addr), .rt_data(rt2)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] e0s, e0t, e1s, e1t, e2s, e2t;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [4:0] ra, input logic [4:0] rb);
    reset      = r;
    wr_enable  = we;
    wr_addr    = wa;
    wr_data    = wd;
    wr_byte_en = be;
    rs_addr    = ra;
    rt_addr    = rb;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      check($sformatf("%s u0 a%0d", tag, a), rs0 | rt0, 32'h0);
      check($sformatf("%s u1 a%0d", tag, a), rs1 | rt1, 32'h0);
      check($sformatf("%s u2 a%0d", tag, a), rs2 | rt2, 32'h0);
    end
  endtask

  initial begin
    //           rst  we  wa  wd             be    ra  rb   u0.rs          u0.rt          u1.rs          u1.rt          u2.rs          u2.rt
    vecs[0]  = '{1'b0,1'b1, 5, 32'd10,       4'hF,  5,  5, 32'd0,         32'd0,         32'd10,        32'd10,        32'd0,         32'd0};
    vecs[1]  = '{1'b0,1'b1, 5, 32'd88,       4'hF,  5,  0, 32'd10,        32'd0,         32'd88,        32'd0,         32'd10,        32'd0};
    vecs[2]  = '{1'b0,1'b0, 5, 32'd89,       4'hF,  5,  5, 32'd88,        32'd88,        32'd88,        32'd88,        32'd88,        32'd88};
    vecs[3]  = '{1'b1,1'b1, 5, 32'h55,       4'hF,  5,  5, 32'd88,        32'd88,        32'd88,        32'd88,        32'd88,        32'd88};
    vecs[4]  = '{1'b0,1'b0, 5, 32'h0,        4'hF,  5,  5, 32'd0,         32'd0,         32'd0,         32'd0,         32'd0,         32'd0};
    vecs[5]  = '{1'b0,1'b1, 7, 32'hAABBCCDD, 4'hF,  7,  0, 32'd0,         32'd0,         32'hAABBCCDD,  32'd0,         32'd0,         32'd0};
    vecs[6]  = '{1'b0,1'b1, 7, 32'h11223344, 4'h5,  7,  7, 32'hAABBCCDD,  32'hAABBCCDD,  32'hAA22CC44,  32'hAA22CC44,  32'hAABBCCDD,  32'hAABBCCDD};
    vecs[7]  = '{1'b0,1'b1, 7, 32'hFFFFFFFF, 4'h0,  7,  7, 32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44};
    vecs[8]  = '{1'b0,1'b0, 7, 32'h0,        4'h0,  7,  7, 32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44,  32'hAA22CC44};
    vecs[9]  = '{1'b0,1'b1, 0, 32'hFFFFFFFF, 4'hF,  0,  0, 32'd0,         32'd0,         32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd0};
    vecs[10] = '{1'b0,1'b0, 0, 32'h0,        4'h0,  0,  0, 32'd0,         32'd0,         32'hFFFFFFFF,  32'hFFFFFFFF,  32'd0,         32'd0};
    vecs[11] = '{1'b0,1'b1, 3, 32'h12345678, 4'hF,  3,  3, 32'd0,         32'd0,         32'h12345678,  32'h12345678,  32'd0,         32'd0};
    vecs[12] = '{1'b0,1'b1, 3, 32'h9ABCDEF0, 4'h3,  3,  3, 32'h12345678,  32'h12345678,  32'h1234DEF0,  32'h1234DEF0,  32'h12345678,  32'h12345678};
    vecs[13] = '{1'b0,1'b0, 3, 32'h0,        4'h0,  3,  3, 32'h1234DEF0,  32'h1234DEF0,  32'h1234DEF0,  32'h1234DEF0,  32'h1234DEF0,  32'h1234DEF0};
    vecs[14] = '{1'b0,1'b1,25, 32'h0000DEAD, 4'hF, 25,  5, 32'd0,         32'd0,         32'h0000DEAD,  32'd0,         32'd0,         32'd0};
    vecs[15] = '{1'b0,1'b0,25, 32'h0,        4'h0, 25,  7, 32'h0000DEAD,  32'hAA22CC44,  32'h0000DEAD,  32'hAA22CC44,  32'd0,         32'hAA22CC44};
    vecs[16] = '{1'b0,1'b1,31, 32'hCAFEF00D, 4'hF, 31,  3, 32'd0,         32'h1234DEF0,  32'hCAFEF00D,  32'h1234DEF0,  32'd0,         32'h1234DEF0};
    vecs[17] = '{1'b0,1'b0,31, 32'h0,        4'h0, 31, 19, 32'hCAFEF00D,  32'd0,         32'hCAFEF00D,  32'd0,         32'd0,         32'd0};
    vecs[18] = '{1'b0,1'b1,19, 32'h01020304, 4'h8, 19, 19, 32'd0,         32'd0,         32'h01000000,  32'h01000000,  32'd0,         32'd0};
    vecs[19] = '{1'b0,1'b0,19, 32'h0,        4'h0, 19,  7, 32'h01000000,  32'hAA22CC44,  32'h01000000,  32'hAA22CC44,  32'h01000000,  32'hAA22CC44};

    // Initial reset, then every address reads zero on both ports.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_all_zero("init");

    // Table: inputs applied after an edge, outputs sampled at the following negedge.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].be, vecs[i].ra, vecs[i].rb);
      @(negedge clk);
      check($sformatf("v%0d u0.rs", i), rs0, vecs[i].e0s);
      check($sformatf("v%0d u0.rt", i), rt0, vecs[i].e0t);
      check($sformatf("v%0d u1.rs", i), rs1, vecs[i].e1s);
      check($sformatf("v%0d u1.rt", i), rt1, vecs[i].e1t);
      check($sformatf("v%0d u2.rs", i), rs2, vecs[i].e2s);
      check($sformatf("v%0d u2.rt", i), rt2, vecs[i].e2t);
    end

    // Reset held two cycles with a write pending: no forward, old contents until the edge.
    @(posedge clk);
    #1 drive(1'b1, 1'b1, 5'd7, 32'h55, 4'hF, 5'd7, 5'd19);
    @(negedge clk);
    check("rstfwd u0.rs", rs0, 32'hAA22CC44);
    check("rstfwd u1.rs", rs1, 32'hAA22CC44);
    check("rstfwd u1.rt", rt1, 32'h01000000);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 5'd7, 32'h55, 4'hF, 5'd7, 5'd3);
    @(negedge clk);
    check("rsthold u0.rs", rs0, 32'h0);
    check("rsthold u1.rt", rt1, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_enable = 1'b0;
    check_all_zero("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
